// File: rtl/aes_cmd_sequencer_if.sv
// Host command, byte-memory and AES-core signals of the CTR sequencer.
// Latency: none, this is wiring only.
// Backpressure: memory uses req/ack (req held until ack); AES uses a start/done pulse pair.
interface aes_cmd_sequencer_if;
    logic [1:0]   cmd;
    logic [15:0]  cmdaddr;
    logic [7:0]   cmddata;
    logic [7:0]   dataout;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata;
    logic         mem_ack;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_in;
    logic [127:0] aes_out;
    logic         aes_done;

    // The sequencer side: drives memory requests, AES controls and read data.
    modport master (
        input  cmd, cmdaddr, cmddata, mem_rdata, mem_ack, aes_out, aes_done,
        output dataout, mem_req, mem_we, mem_addr, mem_wdata, aes_start, aes_key, aes_in
    );

    // The environment side: host, memory and AES core.
    modport slave (
        output cmd, cmdaddr, cmddata, mem_rdata, mem_ack, aes_out, aes_done,
        input  dataout, mem_req, mem_we, mem_addr, mem_wdata, aes_start, aes_key, aes_in
    );
endinterface

// File: rtl/aes_cmd_sequencer.sv
// AES-CTR command sequencer: host register file plus per-16-byte-block load/wait/XOR/store engine.
// Latency: READ data one cycle after the command; START to first memory request one cycle.
// Backpressure: memory req held until ack (1 byte/cycle back-to-back); WAIT stalls until aes_done.
module aes_cmd_sequencer (
    input  logic                clk,
    input  logic                rst,
    aes_cmd_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_WAIT = 2'd2, S_STORE = 2'd3} state_t;

    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    state_t       r_state, w_state_nxt;
    logic [15:0]  r_addr, r_len, r_p, r_r;
    logic [127:0] r_key, r_ctr, r_buf, r_ks;
    logic [3:0]   r_idx;
    logic         r_done_seen;
    logic [7:0]   r_dataout;
    logic         r_mem_req, r_mem_we, r_aes_start;
    logic [15:0]  r_mem_addr;
    logic [7:0]   r_mem_wdata;

    logic         w_wr, w_start, w_ack, w_last, w_blk_end, w_done_now;
    logic [4:0]   w_n;
    logic [3:0]   w_idx_inc;
    logic [15:0]  w_addr_inc;
    logic [7:0]   w_rd_byte, w_next_wdata;

    // Config writes are only honoured while idle; START needs a non-zero length.
    assign w_wr       = (bus.cmd == CMD_WRITE) && (r_state == S_IDLE);
    assign w_start    = w_wr && (bus.cmdaddr == 16'hff00) && (bus.cmddata == 8'h01) && (r_len != 16'd0);
    assign w_ack      = r_mem_req & bus.mem_ack;
    assign w_n        = (r_r >= 16'd16) ? 5'd16 : r_r[4:0];
    assign w_last     = ({1'b0, r_idx} == (w_n - 5'd1));
    assign w_blk_end  = w_ack && w_last;
    assign w_done_now = r_done_seen | bus.aes_done;
    assign w_idx_inc  = r_idx + 4'd1;
    assign w_addr_inc = r_p + {12'd0, w_idx_inc};
    assign w_next_wdata = r_buf[{w_idx_inc, 3'b000} +: 8] ^ r_ks[{w_idx_inc, 3'b000} +: 8];

    assign bus.dataout   = r_dataout;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.aes_start = r_aes_start;
    assign bus.aes_key   = r_key;
    assign bus.aes_in    = r_ctr;

    // Register read mux; status carries the live state code and busy bit.
    always_comb begin
        w_rd_byte = 8'h00;
        if (bus.cmdaddr == 16'hff00)          w_rd_byte = {5'd0, r_state, r_state != S_IDLE};
        else if (bus.cmdaddr == 16'hff02)     w_rd_byte = r_addr[7:0];
        else if (bus.cmdaddr == 16'hff03)     w_rd_byte = r_addr[15:8];
        else if (bus.cmdaddr == 16'hff04)     w_rd_byte = r_len[7:0];
        else if (bus.cmdaddr == 16'hff05)     w_rd_byte = r_len[15:8];
        else if (bus.cmdaddr[15:4] == 12'hff1) w_rd_byte = r_key[{bus.cmdaddr[3:0], 3'b000} +: 8];
        else if (bus.cmdaddr[15:4] == 12'hff2) w_rd_byte = r_ctr[{bus.cmdaddr[3:0], 3'b000} +: 8];
    end

    // Next-state: a block ends on the ack of its last byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)      w_state_nxt = S_LOAD;
            S_LOAD:  if (w_blk_end)    w_state_nxt = w_done_now ? S_STORE : S_WAIT;
            S_WAIT:  if (bus.aes_done) w_state_nxt = S_STORE;
            S_STORE: if (w_blk_end)    w_state_nxt = (r_r == {11'd0, w_n}) ? S_IDLE : S_LOAD;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Config registers, read data, block buffer/keystream and memory/AES drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0; r_len <= '0; r_key <= '0; r_ctr <= '0;
            r_p <= '0; r_r <= '0; r_buf <= '0; r_ks <= '0; r_idx <= '0;
            r_done_seen <= 1'b0; r_dataout <= '0; r_aes_start <= 1'b0;
            r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0; r_mem_wdata <= '0;
        end else begin
            r_aes_start <= 1'b0;
            if (bus.cmd == CMD_READ) r_dataout <= w_rd_byte;
            if (w_wr) begin
                if (bus.cmdaddr == 16'hff02) r_addr[7:0]  <= bus.cmddata;
                if (bus.cmdaddr == 16'hff03) r_addr[15:8] <= bus.cmddata;
                if (bus.cmdaddr == 16'hff04) r_len[7:0]   <= bus.cmddata;
                if (bus.cmdaddr == 16'hff05) r_len[15:8]  <= bus.cmddata;
                if (bus.cmdaddr[15:4] == 12'hff1) r_key[{bus.cmdaddr[3:0], 3'b000} +: 8] <= bus.cmddata;
                if (bus.cmdaddr[15:4] == 12'hff2) r_ctr[{bus.cmdaddr[3:0], 3'b000} +: 8] <= bus.cmddata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_p <= r_addr; r_r <= r_len; r_idx <= '0; r_done_seen <= 1'b0;
                        r_aes_start <= 1'b1;
                        r_mem_req <= 1'b1; r_mem_we <= 1'b0; r_mem_addr <= r_addr;
                    end
                end
                S_LOAD: begin
                    // Keystream may come back while bytes are still loading; keep the first one.
                    if (bus.aes_done && !r_done_seen) begin
                        r_ks <= bus.aes_out; r_done_seen <= 1'b1;
                    end
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1; r_mem_we <= 1'b0; r_mem_addr <= r_p;
                    end else if (w_ack) begin
                        r_buf[{r_idx, 3'b000} +: 8] <= bus.mem_rdata;
                        if (w_last) begin
                            r_mem_req <= 1'b0; r_idx <= '0;
                        end else begin
                            r_idx <= w_idx_inc; r_mem_addr <= w_addr_inc;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.aes_done) r_ks <= bus.aes_out;
                end
                S_STORE: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1; r_mem_we <= 1'b1; r_mem_addr <= r_p;
                        r_mem_wdata <= r_buf[7:0] ^ r_ks[7:0];
                    end else if (w_ack) begin
                        if (w_last) begin
                            r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_idx <= '0;
                            r_p <= r_p + {11'd0, w_n};
                            r_r <= r_r - {11'd0, w_n};
                            r_ctr <= r_ctr + 128'd1;
                            if (r_r != {11'd0, w_n}) begin
                                r_aes_start <= 1'b1; r_done_seen <= 1'b0;
                            end
                        end else begin
                            r_idx <= w_idx_inc; r_mem_addr <= w_addr_inc;
                            r_mem_wdata <= w_next_wdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: register vector table plus multi-cycle CTR runs.
// Latency: checks READ data one cycle after the command and block sequencing against a byte model.
// Backpressure: memory acks every cycle; the AES model answers a start after a programmable delay.
`timescale 1ns/1ps
module tb_aes_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_cmd_sequencer_if bus();
    aes_cmd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed { logic [15:0] a; logic [7:0] d; } xfer_t;
    typedef struct { logic [1:0] cmd; logic [15:0] addr; logic [7:0] data; logic chk; logic [7:0] exp; } vec_t;

    logic [7:0]   mem [0:65535];
    logic [127:0] ks_v = '0;
    int           aes_lat = 3;
    int           aes_cnt = 0;
    int           starts = 0;
    int           req_cycles = 0;
    xfer_t        rd_q[$];
    xfer_t        wr_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    vec_t         vt [22];

    assign bus.mem_ack   = 1'b1;
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.aes_out   = ks_v;

    // Memory transfer logger and AES core model, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_cycles++;
            if (bus.mem_ack) begin
                if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
                else            rd_q.push_back({bus.mem_addr, bus.mem_rdata});
            end
        end
        bus.aes_done = 1'b0;
        if (!rst) aes_cnt = 0;
        else begin
            if (aes_cnt != 0) begin
                aes_cnt--;
                if (aes_cnt == 0) bus.aes_done = 1'b1;
            end
            if (bus.aes_start) begin
                starts++;
                aes_cnt = aes_lat;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cmd = c; bus.cmdaddr = a; bus.cmddata = d;
        @(negedge clk);
        bus.cmd = 2'd0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] e);
        do_cmd(2'd1, a, 8'h00);
        chk(nm, bus.dataout, e);
    endtask

    task automatic set16(input logic [15:0] base, input logic [15:0] v);
        do_cmd(2'd2, base, v[7:0]);
        do_cmd(2'd2, base + 16'd1, v[15:8]);
    endtask

    task automatic set_ctr(input logic [127:0] v);
        for (int i = 0; i < 16; i++) do_cmd(2'd2, 16'hff20 + 16'(i), v[8*i +: 8]);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compares logged traffic from index rb/wb against the byte model for one run.
    task automatic check_run(input string nm, input logic [15:0] base, input int len, input int rb, input int wb);
        logic [15:0] a;
        logic [7:0]  e;
        chk({nm, "_nrd"}, rd_q.size() - rb, len);
        chk({nm, "_nwr"}, wr_q.size() - wb, len);
        for (int i = 0; i < len; i++) begin
            a = base + 16'(i);
            e = mem[a] ^ ks_v[8*(i % 16) +: 8];
            if (rb + i < rd_q.size()) chk($sformatf("%s_rdaddr%0d", nm, i), rd_q[rb+i].a, a);
            if (wb + i < wr_q.size()) begin
                chk($sformatf("%s_wraddr%0d", nm, i), wr_q[wb+i].a, a);
                chk($sformatf("%s_wrdata%0d", nm, i), wr_q[wb+i].d, e);
            end
        end
    endtask

    initial begin
        int rb, wb, s0, q0;
        logic found;
        bus.cmd = 2'd0; bus.cmdaddr = '0; bus.cmddata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vt[0]  = '{2'd1, 16'hff00, 8'h00, 1'b1, 8'h00};
        vt[1]  = '{2'd1, 16'hff02, 8'h00, 1'b1, 8'h00};
        vt[2]  = '{2'd1, 16'hff20, 8'h00, 1'b1, 8'h00};
        vt[3]  = '{2'd2, 16'hff02, 8'h34, 1'b0, 8'h00};
        vt[4]  = '{2'd2, 16'hff03, 8'h12, 1'b0, 8'h00};
        vt[5]  = '{2'd1, 16'hff02, 8'h00, 1'b1, 8'h34};
        vt[6]  = '{2'd1, 16'hff03, 8'h00, 1'b1, 8'h12};
        vt[7]  = '{2'd0, 16'h0000, 8'h00, 1'b1, 8'h12};
        vt[8]  = '{2'd1, 16'hff01, 8'h00, 1'b1, 8'h00};
        vt[9]  = '{2'd2, 16'hff10, 8'h5a, 1'b0, 8'h00};
        vt[10] = '{2'd1, 16'hff10, 8'h00, 1'b1, 8'h5a};
        vt[11] = '{2'd1, 16'hff1f, 8'h00, 1'b1, 8'h00};
        vt[12] = '{2'd2, 16'hff2f, 8'hc3, 1'b0, 8'h00};
        vt[13] = '{2'd1, 16'hff2f, 8'h00, 1'b1, 8'hc3};
        vt[14] = '{2'd1, 16'h1234, 8'h00, 1'b1, 8'h00};
        vt[15] = '{2'd3, 16'hff02, 8'h77, 1'b0, 8'h00};
        vt[16] = '{2'd1, 16'hff02, 8'h00, 1'b1, 8'h34};
        vt[17] = '{2'd2, 16'hff05, 8'hab, 1'b0, 8'h00};
        vt[18] = '{2'd1, 16'hff05, 8'h00, 1'b1, 8'hab};
        vt[19] = '{2'd2, 16'hff00, 8'h02, 1'b0, 8'h00};
        vt[20] = '{2'd1, 16'hff00, 8'h00, 1'b1, 8'h00};
        vt[21] = '{2'd1, 16'hff04, 8'h00, 1'b1, 8'h00};

        // Reset values.
        wait_cyc(3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_dataout", bus.dataout, 8'h00);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
        chk("rst_aes_start", bus.aes_start, 1'b0);
        chk("rst_aes_key", bus.aes_key, 128'd0);
        chk("rst_aes_in", bus.aes_in, 128'd0);

        // Register access table.
        for (int i = 0; i < 22; i++) begin
            do_cmd(vt[i].cmd, vt[i].addr, vt[i].data);
            if (vt[i].chk) chk($sformatf("vec%0d", i), bus.dataout, vt[i].exp);
        end
        chk("no_start_on_0x02", starts, 0);

        // One 16-byte block, keystream bytes 0x00..0x0f, memory zero.
        set_ctr(128'd0);
        set16(16'hff02, 16'h0100);
        set16(16'hff04, 16'd16);
        ks_v = 128'h0f0e0d0c0b0a09080706050403020100;
        aes_lat = 3;
        rb = rd_q.size(); wb = wr_q.size(); s0 = starts;
        do_cmd(2'd2, 16'hff00, 8'h01);
        wait_cyc(60);
        check_run("blk16", 16'h0100, 16, rb, wb);
        chk("blk16_starts", starts - s0, 1);
        rd_chk("blk16_ctr0", 16'hff20, 8'h01);
        rd_chk("blk16_ctr1", 16'hff21, 8'h00);
        rd_chk("blk16_status", 16'hff00, 8'h00);

        // Five bytes wrapping the top of the address space.
        for (int i = 0; i < 5; i++) mem[16'hfffe + 16'(i)] = 8'(8'h11 * (i + 1));
        set16(16'hff02, 16'hfffe);
        set16(16'hff04, 16'd5);
        rb = rd_q.size(); wb = wr_q.size(); s0 = starts;
        do_cmd(2'd2, 16'hff00, 8'h01);
        wait_cyc(40);
        check_run("wrap5", 16'hfffe, 5, rb, wb);
        chk("wrap5_starts", starts - s0, 1);

        // Zero length: no activity at all.
        set16(16'hff04, 16'd0);
        q0 = req_cycles; s0 = starts;
        do_cmd(2'd2, 16'hff00, 8'h01);
        wait_cyc(20);
        chk("len0_req", req_cycles - q0, 0);
        chk("len0_starts", starts - s0, 0);
        rd_chk("len0_status", 16'hff00, 8'h00);

        // Two blocks; START and config writes while busy are dropped.
        set_ctr(128'd0);
        set16(16'hff02, 16'h2000);
        set16(16'hff04, 16'd32);
        rb = rd_q.size(); wb = wr_q.size(); s0 = starts;
        do_cmd(2'd2, 16'hff00, 8'h01);
        rd_chk("run32_status_load", 16'hff00, 8'h03);
        do_cmd(2'd2, 16'hff00, 8'h01);
        do_cmd(2'd2, 16'hff04, 8'h99);
        do_cmd(2'd2, 16'hff20, 8'h77);
        wait_cyc(100);
        check_run("run32", 16'h2000, 32, rb, wb);
        chk("run32_starts", starts - s0, 2);
        rd_chk("run32_len_lo", 16'hff04, 8'h20);
        rd_chk("run32_len_hi", 16'hff05, 8'h00);
        rd_chk("run32_addr_lo", 16'hff02, 8'h00);
        rd_chk("run32_ctr0", 16'hff20, 8'h02);

        // Slow keystream forces the WAIT state.
        for (int i = 0; i < 16; i++) mem[16'h3000 + 16'(i)] = 8'(i * 3);
        for (int i = 0; i < 16; i++) ks_v[8*i +: 8] = 8'(8'ha0 + i);
        aes_lat = 25;
        set16(16'hff02, 16'h3000);
        set16(16'hff04, 16'd16);
        rb = rd_q.size(); wb = wr_q.size();
        do_cmd(2'd2, 16'hff00, 8'h01);
        wait_cyc(17);
        rd_chk("wait_status", 16'hff00, 8'h05);
        chk("wait_req_low", bus.mem_req, 1'b0);
        wait_cyc(60);
        check_run("wait16", 16'h3000, 16, rb, wb);
        aes_lat = 3;

        // All-ones counter wraps to zero.
        set_ctr({128{1'b1}});
        set16(16'hff02, 16'h4000);
        wait_cyc(1);
        do_cmd(2'd2, 16'hff00, 8'h01);
        wait_cyc(60);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("ctrwrap%0d", i), 16'hff20 + 16'(i), 8'h00);

        // Reset during STORE of a 32-byte run.
        set_ctr(128'd5);
        set16(16'hff02, 16'h5000);
        set16(16'hff04, 16'd32);
        do_cmd(2'd2, 16'hff00, 8'h01);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_we) found = 1'b1;
        end
        chk("rst_store_reached", found, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_req", bus.mem_req, 1'b0);
        chk("rst_async_start", bus.aes_start, 1'b0);
        wait_cyc(2);
        rst = 1'b1;
        q0 = req_cycles; s0 = starts;
        wait_cyc(40);
        chk("rst_no_traffic", req_cycles - q0, 0);
        chk("rst_no_start", starts - s0, 0);
        rd_chk("rst_status", 16'hff00, 8'h00);
        rd_chk("rst_ctr0", 16'hff20, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_cmd_sequencer.md
# aes_cmd_sequencer

Command-port controller for the AES accelerator. It decodes host `cmd`/`cmdaddr`/`cmddata` accesses into its configuration registers and, on START_ENCRYPT, runs AES-CTR over a byte buffer in memory. Per 16-byte block it sequences the byte-wide memory port and the AES core: load, wait, XOR, store, then advance. It sits between the host command bus and the AES round datapath.

## Interface
- No parameters; address, length and memory bus are fixed at 16 bits; block is 16 bytes.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd  in  2  0=NOP, 1=READ, 2=WRITE, 3=reserved (treated as NOP)
- cmdaddr  in  16  register address
- cmddata  in  8  write data
- dataout  out  8  read data, registered
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1=write, 0=read
- mem_addr  out  16  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid with mem_ack on a read
- mem_ack  in  1  transfer complete this cycle (only meaningful while mem_req=1)
- aes_start  out  1  one-cycle pulse; core samples aes_key/aes_in
- aes_key  out  128  key register
- aes_in  out  128  counter register
- aes_out  in  128  keystream, valid with aes_done
- aes_done  in  1  one-cycle pulse

## Operation
- Register map (multi-byte registers are little-endian; lowest address = LSB):
  - 0xff00: WRITE 0x01 = START; any other data is ignored. READ returns status.
  - 0xff02–03: addr.
  - 0xff04–05: len, in bytes.
  - 0xff10–1f: key.
  - 0xff20–2f: ctr.
- Reads of any other address return 0x00.
- Status byte: bit0 busy; bits[2:1] state code (IDLE=0, LOAD=1, WAIT=2, STORE=3); all other bits 0.
- Writes to addr, len, key or ctr while busy are ignored. START while busy is ignored.
- START with len=0: stays IDLE, no memory or AES activity.
- FSM:
  - IDLE → LOAD on accepted START. Latch working pointer p=addr and remaining count r=len. Pulse aes_start.
  - LOAD: read n=min(16,r) bytes from p..p+n-1 into buffer byte 0..n-1, one per ack. Capture aes_out on aes_done if it arrives during LOAD (done-seen flag).
    - After the n-th ack: go to STORE if done-seen, else WAIT.
  - WAIT: on aes_done capture aes_out → STORE.
  - STORE: write buffer[i] XOR keystream byte i (byte i = aes_out[8i+7:8i]) to p+i for i=0..n-1.
    - After the n-th ack: p+=n (mod 2^16), r-=n, ctr+=1 (mod 2^128).
    - If r=0 → IDLE; else → LOAD with aes_start pulse.
- The addr and len registers are not modified by a run. ctr is updated in place.
- aes_key/aes_in drive the key/ctr registers continuously.

## Timing
- Reset values:
  - dataout=0x00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, aes_start=0.
  - All registers 0, state IDLE.
- Asserting rst mid-run aborts immediately: mem_req and aes_start drop asynchronously, and buffer contents are discarded.
- READ at cycle t → dataout valid at t+1. dataout holds its value until the next READ.
- START written at cycle t: at t+1 state=LOAD, aes_start=1, mem_req=1, mem_we=0, mem_addr=addr.
- Memory handshake:
  - A transfer completes on each cycle with mem_req&mem_ack.
  - The next byte's address/data is presented the following cycle with mem_req still high, giving back-to-back throughput of 1 byte/cycle.
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and not yet acked.
- mem_req is low for exactly one cycle between the LOAD→STORE and STORE→LOAD transitions and in WAIT.
- A READ of status during a run reflects the state at the cycle of the read.
- aes_done is ignored in IDLE, STORE, and in LOAD after done-seen is set.

## Test plan
- Reset, then READ 0xff00, 0xff02, 0xff20 → dataout 0x00 each. WRITE 0xff02=0x34, 0xff03=0x12; READ both back → 0x34, 0x12.
- key=0, ctr=0, addr=0x0100, len=16, memory all 0x00, mem_ack tied 1, aes_out=0x0f0e…00 with done 3 cycles after start:
  - 16 reads 0x0100..0x010f, then 16 writes of bytes 0x00..0x0f.
  - Then ctr=1 and status=0x00.
- len=5, addr=0xfffe: reads/writes 0xfffe, 0xffff, 0x0000, 0x0001, 0x0002 only; one aes_start.
- len=0 START → no mem_req and no aes_start for 20 cycles. During a run with len=32: START and a WRITE 0xff04=0x99 are ignored; exactly 2 blocks run; len reads back 0x20.
- ctr=all-ones, len=16 → after the run ctr reads 0x00 in all 16 bytes.
- rst low during STORE of a 32-byte run → mem_req=0 in the same cycle; after release state is IDLE, ctr=0, and no further memory traffic.
